// File: rtl/btn_pkg.sv
// Shared types and constants for the button router.
// Destination codes name the consumers wired to each dest_pulse/dest_level slice.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_BLANK    = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_e;

  localparam int unsigned DEST_TOP   = 0;
  localparam int unsigned DEST_ALARM = 1;
  localparam int unsigned DEST_TSET  = 2;
  localparam int unsigned DEST_AUX   = 3;

  // Larger of two unsigned values, for sizing counters at elaboration time.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button bus, followed by a
// previous-value register that yields a one-cycle rising-edge strobe.
module btn_sync_edge
  import btn_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_btn,
  output logic [W-1:0] o_level,
  output logic [W-1:0] o_edge
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  logic [W-1:0] r_prev;

  // Synchroniser chain plus one-cycle history for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_edge  = r_sync & ~r_prev;

endmodule

// File: rtl/btn_router.sv
// Button router: steers synchronised press pulses and held levels to the
// destination chosen by sel. A select change blanks all outputs for BLANK_CYC
// cycles and then waits until every button is released before re-arming, so a
// press overlapping a mode change never reaches the new destination.
// Optional auto-repeat of held buttons is enabled by defining BTN_ROUTER_REPEAT_EN.
module btn_router
  import btn_pkg::*;
#(
  parameter int unsigned BTN_W      = 5,
  parameter int unsigned N_DEST     = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned BLANK_CYC  = 16
`ifdef BTN_ROUTER_REPEAT_EN
  ,
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BTN_W-1:0]        btn_in,
  input  logic [SEL_W-1:0]        sel,
  output logic [N_DEST*BTN_W-1:0] dest_pulse,
  output logic [N_DEST*BTN_W-1:0] dest_level,
  output logic [SEL_W-1:0]        active_dest,
  output logic                    busy
);

  localparam int unsigned BLANK_W = $clog2(BLANK_CYC + 1);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYC - 1);

  logic [BTN_W-1:0]        w_level;
  logic [BTN_W-1:0]        w_edge;
  logic [BTN_W-1:0]        w_fire;
  logic [SEL_W-1:0]        w_sel_map;
  logic                    w_sel_chg;
  logic [N_DEST*BTN_W-1:0] w_pulse_route;
  logic [N_DEST*BTN_W-1:0] w_level_route;

  logic [SEL_W-1:0]        r_sel_q;
  logic [SEL_W-1:0]        r_active_dest;
  state_e                  r_state;
  logic [BLANK_W-1:0]      r_cnt;
  logic                    r_busy;
  logic [N_DEST*BTN_W-1:0] r_pulse;
  logic [N_DEST*BTN_W-1:0] r_level;

  btn_sync_edge #(
    .W (BTN_W)
  ) u_sync_edge (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_btn   (btn_in),
    .o_level (w_level),
    .o_edge  (w_edge)
  );

  // Register the select so the change detector sees a stable value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_q <= '0;
    end else begin
      r_sel_q <= sel;
    end
  end

  // Out-of-range selects fall back to the top-level display.
  always_comb begin
    w_sel_map = r_sel_q;
    if (32'(r_sel_q) >= N_DEST) begin
      w_sel_map = SEL_W'(DEST_TOP);
    end
    w_sel_chg = (w_sel_map != r_active_dest);
  end

`ifdef BTN_ROUTER_REPEAT_EN
  localparam int unsigned REP_W = $clog2(max_u(HOLD_CYC, REPEAT_CYC) + 1);

  logic [REP_W-1:0] r_rep_cnt [BTN_W];
  logic [BTN_W-1:0] w_rep;

  // Per-button hold counter: loaded on the press edge, reloaded on each repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTN_W; i++) begin
        r_rep_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BTN_W; i++) begin
        if ((r_state != ST_ARMED) || w_sel_chg || !w_level[i]) begin
          r_rep_cnt[i] <= '0;
        end else if (w_edge[i]) begin
          r_rep_cnt[i] <= REP_W'(HOLD_CYC - 1);
        end else if (r_rep_cnt[i] == '0) begin
          r_rep_cnt[i] <= REP_W'(REPEAT_CYC - 1);
        end else begin
          r_rep_cnt[i] <= r_rep_cnt[i] - 1'b1;
        end
      end
    end
  end

  // A held button whose counter expired produces a repeat pulse.
  always_comb begin
    w_rep = '0;
    for (int i = 0; i < BTN_W; i++) begin
      w_rep[i] = w_level[i] & ~w_edge[i] & (r_rep_cnt[i] == '0) & (r_state == ST_ARMED);
    end
  end

  assign w_fire = w_edge | w_rep;
`else
  assign w_fire = w_edge;
`endif

  // Place pulses and levels into the active destination's slice only.
  always_comb begin
    w_pulse_route = '0;
    w_level_route = '0;
    for (int unsigned d = 0; d < N_DEST; d++) begin
      if (32'(r_active_dest) == d) begin
        w_pulse_route[d*BTN_W +: BTN_W] = w_fire;
        w_level_route[d*BTN_W +: BTN_W] = w_level;
      end
    end
  end

  // Mode FSM with registered outputs; a select change overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BLANK;
      r_cnt         <= BLANK_LOAD;
      r_active_dest <= '0;
      r_busy        <= 1'b0;
      r_pulse       <= '0;
      r_level       <= '0;
    end else begin
      r_pulse <= '0;
      r_level <= '0;
      if (w_sel_chg) begin
        // The new destination is latched now; any press this cycle is dropped.
        r_state       <= ST_BLANK;
        r_cnt         <= BLANK_LOAD;
        r_active_dest <= w_sel_map;
        r_busy        <= 1'b1;
      end else begin
        unique case (r_state)
          ST_ARMED: begin
            r_pulse <= w_pulse_route;
            r_level <= w_level_route;
            r_busy  <= 1'b0;
          end
          ST_BLANK: begin
            r_busy <= 1'b1;
            if (r_cnt == '0) begin
              r_state <= ST_WAIT_REL;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_WAIT_REL: begin
            if (w_level == '0) begin
              r_state <= ST_ARMED;
              r_busy  <= 1'b0;
            end else begin
              r_busy <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_BLANK;
            r_cnt   <= BLANK_LOAD;
            r_busy  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign dest_pulse  = r_pulse;
  assign dest_level  = r_level;
  assign active_dest = r_active_dest;
  assign busy        = r_busy;

endmodule
